// File: rtl/edfic_dispatch_if.sv
// Core-side handshake bundle for edfic_dispatch: arbiter winner in, offer/claim/complete, status out.
interface edfic_dispatch_if #(
   parameter int unsigned NrInputs  = 32,
   parameter int unsigned PrioWidth = 8,
   parameter int unsigned Depth     = 4
);
   localparam int unsigned IdxWidth   = $clog2(NrInputs);
   localparam int unsigned DepthWidth = $clog2(Depth + 1);

   logic                  arb_valid_i;
   logic [PrioWidth-1:0]  arb_prio_i;
   logic [IdxWidth-1:0]   arb_idx_i;
   logic                  irq_valid_o;
   logic [PrioWidth-1:0]  irq_prio_o;
   logic [IdxWidth-1:0]   irq_idx_o;
   logic                  irq_ready_i;
   logic                  claim_o;
   logic [IdxWidth-1:0]   claim_idx_o;
   logic                  complete_i;
   logic [IdxWidth-1:0]   complete_idx_i;
   logic                  thresh_valid_o;
   logic [PrioWidth-1:0]  thresh_prio_o;
   logic [DepthWidth-1:0] depth_o;
   logic                  err_o;

   modport slave (
      input  arb_valid_i, arb_prio_i, arb_idx_i, irq_ready_i, complete_i, complete_idx_i,
      output irq_valid_o, irq_prio_o, irq_idx_o, claim_o, claim_idx_o,
             thresh_valid_o, thresh_prio_o, depth_o, err_o
   );

   modport master (
      output arb_valid_i, arb_prio_i, arb_idx_i, irq_ready_i, complete_i, complete_idx_i,
      input  irq_valid_o, irq_prio_o, irq_idx_o, claim_o, claim_idx_o,
             thresh_valid_o, thresh_prio_o, depth_o, err_o
   );
endinterface

// File: rtl/edfic_dispatch.sv
// Earliest-deadline interrupt dispatcher with in-service stack.
// Define EDFIC_NESTING_EN for Depth-deep preemptive nesting; otherwise one handler at a time.
module edfic_dispatch #(
   parameter int unsigned NrInputs  = 32,
   parameter int unsigned PrioWidth = 8,
   parameter int unsigned Depth     = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   edfic_dispatch_if.slave bus
);
   localparam int unsigned IdxWidth   = $clog2(NrInputs);
   localparam int unsigned DepthWidth = $clog2(Depth + 1);
`ifdef EDFIC_NESTING_EN
   localparam int unsigned EffDepth = Depth;
`else
   localparam int unsigned EffDepth = 1;
`endif

   typedef enum logic [1:0] {StIdle, StOffer, StSettle} state_e;

   state_e                state_q;
   logic [IdxWidth-1:0]   stk_idx_q  [EffDepth];
   logic [IdxWidth-1:0]   stk_idx_d  [EffDepth];
   logic [PrioWidth-1:0]  stk_prio_q [EffDepth];
   logic [PrioWidth-1:0]  stk_prio_d [EffDepth];
   logic [DepthWidth-1:0] depth_q, depth_mid, depth_d;
   logic [IdxWidth-1:0]   top_idx, irq_idx_q;
   logic [PrioWidth-1:0]  irq_prio_q, thresh_prio_q, thresh_prio_d;
   logic                  irq_valid_q, thresh_valid_q, err_q;
   logic                  accept, pop, bad_complete, start;

   assign accept = (state_q == StOffer) && bus.irq_ready_i;

   always_comb begin
      top_idx = '0;
      for (int i = 0; i < int'(EffDepth); i++) begin
         if (DepthWidth'(i + 1) == depth_q) top_idx = stk_idx_q[i];
      end
   end

   assign pop          = bus.complete_i && (depth_q != '0) && (bus.complete_idx_i == top_idx);
   assign bad_complete = bus.complete_i && !pop;
   // Strict less-than: an equal deadline never preempts the handler in service.
   assign start = (state_q == StIdle) && bus.arb_valid_i &&
                  (depth_q < DepthWidth'(EffDepth)) &&
                  ((depth_q == '0) || ($signed(bus.arb_prio_i) < $signed(thresh_prio_q)));

   // Pop is applied before push so a same-cycle complete and accept replace the top entry.
   always_comb begin
      depth_mid     = pop ? depth_q - DepthWidth'(1) : depth_q;
      depth_d       = depth_mid + DepthWidth'(accept);
      thresh_prio_d = '0;
      for (int i = 0; i < int'(EffDepth); i++) begin
         stk_idx_d[i]  = stk_idx_q[i];
         stk_prio_d[i] = stk_prio_q[i];
         if (accept && DepthWidth'(i) == depth_mid) begin
            stk_idx_d[i]  = irq_idx_q;
            stk_prio_d[i] = irq_prio_q;
         end
      end
      for (int i = 0; i < int'(EffDepth); i++) begin
         if (DepthWidth'(i + 1) == depth_d) thresh_prio_d = stk_prio_d[i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= StIdle;
         irq_valid_q    <= 1'b0;
         irq_prio_q     <= '0;
         irq_idx_q      <= '0;
         depth_q        <= '0;
         thresh_valid_q <= 1'b0;
         thresh_prio_q  <= '0;
         err_q          <= 1'b0;
         for (int i = 0; i < int'(EffDepth); i++) begin
            stk_idx_q[i]  <= '0;
            stk_prio_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q     <= StOffer;
                  irq_valid_q <= 1'b1;
                  irq_prio_q  <= bus.arb_prio_i;
                  irq_idx_q   <= bus.arb_idx_i;
               end
            end
            StOffer: begin
               if (bus.irq_ready_i) begin
                  state_q     <= StSettle;
                  irq_valid_q <= 1'b0;
               end
            end
            StSettle: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
         depth_q        <= depth_d;
         thresh_valid_q <= (depth_d != '0);
         thresh_prio_q  <= thresh_prio_d;
         err_q          <= err_q | bad_complete;
         for (int i = 0; i < int'(EffDepth); i++) begin
            stk_idx_q[i]  <= stk_idx_d[i];
            stk_prio_q[i] <= stk_prio_d[i];
         end
      end
   end

   assign bus.irq_valid_o    = irq_valid_q;
   assign bus.irq_prio_o     = irq_prio_q;
   assign bus.irq_idx_o      = irq_idx_q;
   assign bus.claim_o        = accept;
   assign bus.claim_idx_o    = irq_idx_q;
   assign bus.thresh_valid_o = thresh_valid_q;
   assign bus.thresh_prio_o  = thresh_prio_q;
   assign bus.depth_o        = depth_q;
   assign bus.err_o          = err_q;
endmodule

// File: tb/tb_edfic_dispatch.sv
// Directed bench for edfic_dispatch; expectations follow EDFIC_NESTING_EN when defined.
module tb_edfic_dispatch;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   edfic_dispatch_if #(.NrInputs(32), .PrioWidth(8), .Depth(4)) bus ();

   edfic_dispatch #(.NrInputs(32), .PrioWidth(8), .Depth(4)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      bus.arb_valid_i    = 1'b0;
      bus.arb_prio_i     = '0;
      bus.arb_idx_i      = '0;
      bus.irq_ready_i    = 1'b0;
      bus.complete_i     = 1'b0;
      bus.complete_idx_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   // Offer then accept on the first OFFER cycle, leaving the DUT back in IDLE.
   task automatic accept(input logic [7:0] prio, input logic [4:0] idx);
      bus.arb_valid_i = 1'b1;
      bus.arb_prio_i  = prio;
      bus.arb_idx_i   = idx;
      tick();
      bus.arb_valid_i = 1'b0;
      bus.irq_ready_i = 1'b1;
      tick();
      bus.irq_ready_i = 1'b0;
      tick();
   endtask

   task automatic complete(input logic [4:0] idx);
      bus.complete_i     = 1'b1;
      bus.complete_idx_i = idx;
      tick();
      bus.complete_i     = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_i = 1'b1;
      #2;
      n_chk++; if ({bus.irq_valid_o, bus.irq_prio_o, bus.irq_idx_o} !== 14'd0)
         $display("FAIL reset_irq got=%h want=0", {bus.irq_valid_o, bus.irq_prio_o, bus.irq_idx_o});
      else n_pass++;
      n_chk++; if ({bus.thresh_valid_o, bus.thresh_prio_o, bus.depth_o, bus.err_o, bus.claim_o} !== 14'd0)
         $display("FAIL reset_status got=%h want=0",
                  {bus.thresh_valid_o, bus.thresh_prio_o, bus.depth_o, bus.err_o, bus.claim_o});
      else n_pass++;
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bus.arb_valid_i = 1'b1;
      bus.arb_prio_i  = 8'd5;
      bus.arb_idx_i   = 5'd3;
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.irq_prio_o, bus.irq_idx_o} !== {1'b1, 8'd5, 5'd3})
         $display("FAIL basic_offer got=%b/%0d/%0d want=1/5/3", bus.irq_valid_o, bus.irq_prio_o, bus.irq_idx_o);
      else n_pass++;
      n_chk++; if (bus.claim_o !== 1'b0) $display("FAIL basic_noclaim got=%b want=0", bus.claim_o);
      else n_pass++;
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.irq_idx_o} !== {1'b1, 5'd3})
         $display("FAIL basic_hold got=%b/%0d want=1/3", bus.irq_valid_o, bus.irq_idx_o);
      else n_pass++;
      bus.irq_ready_i = 1'b1;
      bus.arb_valid_i = 1'b0;
      #1;
      n_chk++; if ({bus.claim_o, bus.claim_idx_o} !== {1'b1, 5'd3})
         $display("FAIL basic_claim got=%b/%0d want=1/3", bus.claim_o, bus.claim_idx_o);
      else n_pass++;
      tick();
      bus.irq_ready_i = 1'b0;
      n_chk++; if ({bus.claim_o, bus.irq_valid_o} !== 2'b00)
         $display("FAIL basic_settle got=%b%b want=00", bus.claim_o, bus.irq_valid_o);
      else n_pass++;
      n_chk++; if ({bus.depth_o, bus.thresh_valid_o, bus.thresh_prio_o} !== {3'd1, 1'b1, 8'd5})
         $display("FAIL basic_stack got=%0d/%b/%0d want=1/1/5", bus.depth_o, bus.thresh_valid_o, bus.thresh_prio_o);
      else n_pass++;
      tick();
      complete(5'd3);
      n_chk++; if ({bus.depth_o, bus.thresh_valid_o, bus.thresh_prio_o} !== 12'd0)
         $display("FAIL basic_pop got=%0d/%b/%0d want=0/0/0", bus.depth_o, bus.thresh_valid_o, bus.thresh_prio_o);
      else n_pass++;
   endtask

   task automatic test_preempt();
      accept(8'd5, 5'd3);
      bus.arb_valid_i = 1'b1;
      bus.arb_prio_i  = 8'hFE;
      bus.arb_idx_i   = 5'd7;
      tick();
`ifdef EDFIC_NESTING_EN
      n_chk++; if ({bus.irq_valid_o, bus.irq_idx_o} !== {1'b1, 5'd7})
         $display("FAIL preempt_offer got=%b/%0d want=1/7", bus.irq_valid_o, bus.irq_idx_o);
      else n_pass++;
      bus.arb_valid_i = 1'b0;
      bus.irq_ready_i = 1'b1;
      tick();
      bus.irq_ready_i = 1'b0;
      n_chk++; if ({bus.depth_o, bus.thresh_prio_o} !== {3'd2, 8'hFE})
         $display("FAIL preempt_depth got=%0d/%h want=2/fe", bus.depth_o, bus.thresh_prio_o);
      else n_pass++;
      tick();
      complete(5'd7);
      complete(5'd3);
`else
      tick();
      tick();
      n_chk++; if (bus.irq_valid_o !== 1'b0) $display("FAIL preempt_block got=%b want=0", bus.irq_valid_o);
      else n_pass++;
      complete(5'd3);
      n_chk++; if ({bus.irq_valid_o, bus.depth_o} !== {1'b0, 3'd0})
         $display("FAIL preempt_popped got=%b/%0d want=0/0", bus.irq_valid_o, bus.depth_o);
      else n_pass++;
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.irq_idx_o} !== {1'b1, 5'd7})
         $display("FAIL preempt_late got=%b/%0d want=1/7", bus.irq_valid_o, bus.irq_idx_o);
      else n_pass++;
      bus.arb_valid_i = 1'b0;
      bus.irq_ready_i = 1'b1;
      tick();
      bus.irq_ready_i = 1'b0;
      tick();
      complete(5'd7);
`endif
      n_chk++; if ({bus.depth_o, bus.err_o} !== {3'd0, 1'b0})
         $display("FAIL preempt_end got=%0d/%b want=0/0", bus.depth_o, bus.err_o);
      else n_pass++;
   endtask

   task automatic test_equal();
      accept(8'd5, 5'd3);
      bus.arb_valid_i = 1'b1;
      bus.arb_prio_i  = 8'd5;
      bus.arb_idx_i   = 5'd9;
      tick();
      tick();
      n_chk++; if (bus.irq_valid_o !== 1'b0) $display("FAIL equal_nopreempt got=%b want=0", bus.irq_valid_o);
      else n_pass++;
      complete(5'd3);
      n_chk++; if ({bus.depth_o, bus.irq_valid_o} !== {3'd0, 1'b0})
         $display("FAIL equal_pop got=%0d/%b want=0/0", bus.depth_o, bus.irq_valid_o);
      else n_pass++;
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.irq_idx_o} !== {1'b1, 5'd9})
         $display("FAIL equal_offer got=%b/%0d want=1/9", bus.irq_valid_o, bus.irq_idx_o);
      else n_pass++;
      bus.arb_valid_i = 1'b0;
      bus.irq_ready_i = 1'b1;
      tick();
      bus.irq_ready_i = 1'b0;
      tick();
      complete(5'd9);
   endtask

   task automatic test_err();
      do_reset();
      complete(5'd0);
      n_chk++; if ({bus.err_o, bus.depth_o} !== {1'b1, 3'd0})
         $display("FAIL err_empty got=%b/%0d want=1/0", bus.err_o, bus.depth_o);
      else n_pass++;
      do_reset();
      n_chk++; if (bus.err_o !== 1'b0) $display("FAIL err_reset got=%b want=0", bus.err_o);
      else n_pass++;
      accept(8'd5, 5'd3);
      complete(5'd4);
      n_chk++; if ({bus.err_o, bus.depth_o, bus.thresh_prio_o} !== {1'b1, 3'd1, 8'd5})
         $display("FAIL err_mismatch got=%b/%0d/%0d want=1/1/5", bus.err_o, bus.depth_o, bus.thresh_prio_o);
      else n_pass++;
      tick();
      complete(5'd3);
      n_chk++; if ({bus.err_o, bus.depth_o} !== {1'b1, 3'd0})
         $display("FAIL err_sticky got=%b/%0d want=1/0", bus.err_o, bus.depth_o);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_full();
`ifdef EDFIC_NESTING_EN
      accept(8'd10, 5'd1);
      accept(8'd6, 5'd2);
      accept(8'd2, 5'd3);
      accept(8'hFF, 5'd4);
      bus.arb_valid_i = 1'b1;
      bus.arb_prio_i  = 8'hF8;
      bus.arb_idx_i   = 5'd5;
      tick();
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.depth_o, bus.thresh_prio_o} !== {1'b0, 3'd4, 8'hFF})
         $display("FAIL full_block got=%b/%0d/%h want=0/4/ff", bus.irq_valid_o, bus.depth_o, bus.thresh_prio_o);
      else n_pass++;
      complete(5'd4);
      n_chk++; if ({bus.depth_o, bus.thresh_prio_o} !== {3'd3, 8'd2})
         $display("FAIL full_pop got=%0d/%0d want=3/2", bus.depth_o, bus.thresh_prio_o);
      else n_pass++;
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.irq_idx_o} !== {1'b1, 5'd5})
         $display("FAIL full_offer got=%b/%0d want=1/5", bus.irq_valid_o, bus.irq_idx_o);
      else n_pass++;
      bus.arb_valid_i    = 1'b0;
      bus.irq_ready_i    = 1'b1;
      bus.complete_i     = 1'b1;
      bus.complete_idx_i = 5'd3;
      #1;
      n_chk++; if ({bus.claim_o, bus.claim_idx_o} !== {1'b1, 5'd5})
         $display("FAIL full_claim got=%b/%0d want=1/5", bus.claim_o, bus.claim_idx_o);
      else n_pass++;
      tick();
      clear_inputs();
      n_chk++; if ({bus.depth_o, bus.thresh_prio_o, bus.err_o} !== {3'd3, 8'hF8, 1'b0})
         $display("FAIL full_swap got=%0d/%h/%b want=3/f8/0", bus.depth_o, bus.thresh_prio_o, bus.err_o);
      else n_pass++;
      tick();
      complete(5'd5);
      n_chk++; if ({bus.depth_o, bus.thresh_prio_o} !== {3'd2, 8'd6})
         $display("FAIL full_under got=%0d/%0d want=2/6", bus.depth_o, bus.thresh_prio_o);
      else n_pass++;
`else
      accept(8'd10, 5'd1);
      bus.arb_valid_i = 1'b1;
      bus.arb_prio_i  = 8'hF8;
      bus.arb_idx_i   = 5'd5;
      tick();
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.depth_o} !== {1'b0, 3'd1})
         $display("FAIL full_block got=%b/%0d want=0/1", bus.irq_valid_o, bus.depth_o);
      else n_pass++;
      complete(5'd1);
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.irq_idx_o} !== {1'b1, 5'd5})
         $display("FAIL full_offer got=%b/%0d want=1/5", bus.irq_valid_o, bus.irq_idx_o);
      else n_pass++;
      bus.arb_valid_i    = 1'b0;
      bus.irq_ready_i    = 1'b1;
      bus.complete_i     = 1'b1;
      bus.complete_idx_i = 5'd0;
      tick();
      clear_inputs();
      n_chk++; if ({bus.depth_o, bus.thresh_prio_o, bus.err_o} !== {3'd1, 8'hF8, 1'b1})
         $display("FAIL full_badpush got=%0d/%h/%b want=1/f8/1", bus.depth_o, bus.thresh_prio_o, bus.err_o);
      else n_pass++;
`endif
      do_reset();
   endtask

   task automatic test_reset_offer();
      bus.arb_valid_i = 1'b1;
      bus.arb_prio_i  = 8'd5;
      bus.arb_idx_i   = 5'd3;
      tick();
      bus.irq_ready_i = 1'b1;
      #1;
      n_chk++; if (bus.claim_o !== 1'b1) $display("FAIL rstoffer_pre got=%b want=1", bus.claim_o);
      else n_pass++;
      rst_i = 1'b1;
      #1;
      n_chk++; if ({bus.irq_valid_o, bus.claim_o, bus.irq_prio_o, bus.irq_idx_o} !== 15'd0)
         $display("FAIL rstoffer_drop got=%h want=0", {bus.irq_valid_o, bus.claim_o, bus.irq_prio_o, bus.irq_idx_o});
      else n_pass++;
      n_chk++; if ({bus.depth_o, bus.thresh_valid_o, bus.thresh_prio_o, bus.err_o} !== 13'd0)
         $display("FAIL rstoffer_stack got=%h want=0", {bus.depth_o, bus.thresh_valid_o, bus.thresh_prio_o, bus.err_o});
      else n_pass++;
      @(negedge clk_i);
      clear_inputs();
      rst_i = 1'b0;
      tick();
      tick();
      n_chk++; if ({bus.irq_valid_o, bus.depth_o} !== {1'b0, 3'd0})
         $display("FAIL rstoffer_after got=%b/%0d want=0/0", bus.irq_valid_o, bus.depth_o);
      else n_pass++;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_basic();
      test_preempt();
      test_equal();
      test_err();
      test_full();
      test_reset_offer();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
